// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell processes the operands LSB first,
// one bit per clock, through an IDLE -> RUN -> DONE sequencer with registered outputs.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic             sub_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;

    logic b_bit;
    logic sum_bit;
    logic carry_next;

    // Subtraction is a + ~b + 1: invert b per bit and preload the carry with sub.
    always_comb begin
        b_bit      = b_sr_reg[0] ^ sub_reg;
        sum_bit    = a_sr_reg[0] ^ b_bit ^ carry_reg;
        carry_next = (a_sr_reg[0] & b_bit) | (carry_reg & (a_sr_reg[0] ^ b_bit));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_sr_reg  <= '0;
            b_sr_reg  <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr_reg  <= a;
                        b_sr_reg  <= b;
                        sub_reg   <= sub;
                        carry_reg <= sub;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_sr_reg  <= {1'b0, a_sr_reg[WIDTH-1:1]};
                    b_sr_reg  <= {1'b0, b_sr_reg[WIDTH-1:1]};
                    result    <= {sum_bit, result[WIDTH-1:1]};
                    carry_reg <= carry_next;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_BIT) begin
                        // carry_reg here is the carry into the MSB, carry_next the carry out.
                        c_out     <= carry_next;
                        ovf       <= carry_reg ^ carry_next;
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // done is registered from DONE, so it appears WIDTH+1 edges after start.
                    done      <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: the driver queues arithmetic expectations,
// a monitor pops and compares on every done pulse.
module tb_serial_addsub;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         ovf;

    serial_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .c_out(c_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           start_cyc;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string name, longint got, longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    // Reference: plain integer arithmetic, unsigned for carry, signed range for overflow.
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic s, int sc);
        exp_t e;
        int ux, uy, sx, sy, r, sr;
        ux = int'(x);
        uy = int'(y);
        sx = x[W-1] ? ux - (1 << W) : ux;
        sy = y[W-1] ? uy - (1 << W) : uy;
        if (!s) begin
            r    = ux + uy;
            e.co = (r >= (1 << W));
            sr   = sx + sy;
        end else begin
            r    = ux - uy;
            e.co = (ux >= uy);
            sr   = sx - sy;
        end
        e.res       = r[W-1:0];
        e.ov        = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        e.start_cyc = sc;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", result, e.res);
                    check("c_out", c_out, e.co);
                    check("ovf", ovf, e.ov);
                    check("latency", cyc - e.start_cyc, W + 1);
                    $display("op done: result=0x%0h c_out=%0b ovf=%0b at cycle %0d", result, c_out, ovf, cyc);
                end
            end
        end
    end

    // One operation; poke_at >= 0 re-pulses start with a changed operand during RUN.
    task automatic run_op(logic [W-1:0] x, logic [W-1:0] y, logic s, int poke_at);
        exp_t e;
        int   busy_cnt;
        bit   seen;
        @(negedge clk);
        a     = x;
        b     = y;
        sub   = s;
        start = 1'b1;
        e = model(x, y, s, cyc + 1);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        sub   = 1'($urandom);
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 30; i++) begin
            start = (i == poke_at);
            if (i == poke_at) a = 8'hAA;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("busy_cycles", busy_cnt, W);
        repeat (3) @(negedge clk);
        check("hold_result", result, e.res);
        check("hold_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        sub   = 1'b0;
        a     = 8'h12;
        b     = 8'h34;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_c_out", c_out, 0);
        check("rst_ovf", ovf, 0);
        start = 1'b0;
        rst   = 1'b0;

        run_op(8'h5A, 8'h3C, 1'b0, -1);
        run_op(8'hFF, 8'h01, 1'b0, -1);
        run_op(8'h10, 8'h20, 1'b1, -1);
        run_op(8'h80, 8'h01, 1'b1, -1);
        run_op(8'h01, 8'h02, 1'b0, 3);

        // Abort mid-RUN: rst lands on the edge that would process bit 4.
        @(negedge clk);
        a     = 8'h11;
        b     = 8'h22;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_c_out", c_out, 0);
        check("abort_ovf", ovf, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        run_op(8'h03, 8'h04, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), -1);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand/result width in bits (legal range 2..32).
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have port sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-007 SHALL have port a  input  WIDTH  first operand; sampled with start.
REQ-008 SHALL have port b  input  WIDTH  second operand; sampled with start.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-011 SHALL have port result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-012 SHALL have port c_out  output  1  carry out of the MSB; for subtract, 1 = no borrow (a >= b unsigned).
REQ-013 SHALL have port ovf  output  1  two's-complement overflow.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE with start=1 SHALL load a, b and sub into internal shift registers. It SHALL load the carry flop with sub, clear the bit counter, and go to RUN.
REQ-016 IDLE with start=0 SHALL hold all registers and outputs.
REQ-017 RUN SHALL process one bit per cycle, LSB first, through a single full-adder cell.
- Cell inputs: a bit, b bit XOR sub, carry flop.
- Cell outputs: the sum bit shifts into result from the MSB side; cell carry-out goes to the carry flop.
REQ-018 RUN SHALL last exactly WIDTH cycles. On the edge that processes bit WIDTH-1, it SHALL go to DONE.
- c_out latches the final carry.
- ovf latches (carry into MSB) XOR (carry out of MSB).
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 Latency: if start is sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH+1.
- That is, done becomes visible WIDTH+1 edges after the start edge.
REQ-021 result, c_out and ovf SHALL hold their values from DONE until the next accepted start.
- They are don't-care while busy=1.
REQ-022 busy SHALL be 1 exactly during the WIDTH RUN cycles, and 0 in IDLE and DONE.
REQ-023 start SHALL be ignored in RUN and DONE.
- Operands and mode SHALL NOT change mid-operation.
- No request SHALL be queued.
REQ-024 Changes on a, b or sub after the start edge SHALL NOT affect the result.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-026 rst=1 at a clock edge SHALL force the FSM to IDLE, regardless of state (including mid-RUN).
REQ-027 While rst=1: busy=0, done=0, result=0, c_out=0, ovf=0, and the counter and carry flop are cleared.
REQ-028 rst SHALL take priority over start in the same cycle.
REQ-029 An operation aborted by reset SHALL produce no done pulse.
REQ-030 The first start after reset is released SHALL be accepted normally.

Verification (WIDTH=8)
REQ-031 Add with overflow: a=0x5A, b=0x3C, sub=0 -> result=0x96, c_out=0, ovf=1. done occurs exactly 9 edges after start, and busy is high for 8 cycles.
REQ-032 Add with wrap-around: a=0xFF, b=0x01, sub=0 -> result=0x00, c_out=1, ovf=0.
REQ-033 Subtract with borrow: a=0x10, b=0x20, sub=1 -> result=0xF0, c_out=0, ovf=0.
REQ-034 Subtract with signed overflow: a=0x80, b=0x01, sub=1 -> result=0x7F, c_out=1, ovf=1.
REQ-035 Start and operand change while busy:
- Stimulus: start with a=0x01, b=0x02, add; during RUN, pulse start with a=0xAA.
- Required: result=0x03, exactly one done pulse, and the second start is ignored.
REQ-036 Reset mid-operation:
- Stimulus: assert rst at RUN bit 4, then issue a new start with 0x03+0x04.
- Required: all outputs are 0 and no done pulse follows the reset; the new operation gives result=0x07 with done 9 edges later.
